// File: rtl/bp_net_seq_if.sv
// Sample-in and result-out streams of the BP inference sequencer.
// The sequencer uses the slave modport. The producer/consumer uses the master modport.
interface bp_net_seq_if #(
    parameter int XW = 9,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] in_x;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_y;

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_y
    );

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_y
    );
endinterface

// File: rtl/bp_net_seq.sv
// Inference sequencer for the two-layer BP network: sample -> layer 1 -> layer 2 -> result.
// Owns the shared weight ROM address mux and aborts any stage that overruns TIMEOUT cycles.
module bp_net_seq #(
    parameter int XW      = 9,
    parameter int DW      = 32,
    parameter int NH      = 4,
    parameter int AW      = 6,
    parameter int L2_BASE = 40,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    bp_net_seq_if.slave        str,

    output logic               l1_en_o,
    output logic [XW-1:0]      l1_x_o,
    input  logic               l1_valid_i,
    input  logic [NH*DW-1:0]   l1_y_i,
    input  logic [AW-1:0]      l1_rom_addr_i,

    output logic               l2_en_o,
    output logic [NH*DW-1:0]   l2_h_o,
    input  logic               l2_valid_i,
    input  logic [DW-1:0]      l2_y_i,
    input  logic [AW-1:0]      l2_rom_addr_i,

    output logic [AW-1:0]      rom_addr_o,
    output logic               busy_o,
    output logic               err_timeout_o
);
    localparam int CW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L1   = 2'd1,
        L2   = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic               l1_en_q;
    logic               l2_en_q;
    logic               out_valid_q;
    logic               in_ready_q;
    logic               busy_q;
    logic               err_q;
    logic [XW-1:0]      l1_x_q;
    logic [NH*DW-1:0]   l2_h_q;
    logic [DW-1:0]      out_y_q;
    logic [AW-1:0]      l2_addr_abs;

    // Saturating stage counter: sticks at all-ones instead of wrapping.
    assign cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            l1_en_q     <= 1'b0;
            l2_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            l1_x_q      <= '0;
            l2_h_q      <= '0;
            out_y_q     <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (str.in_valid) begin
                        l1_x_q     <= str.in_x;
                        cnt_q      <= '0;
                        l1_en_q    <= 1'b1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= L1;
                    end
                end
                L1: begin
                    // A valid arriving on the last allowed cycle still beats the abort.
                    if (l1_valid_i) begin
                        l2_h_q  <= l1_y_i;
                        cnt_q   <= '0;
                        l1_en_q <= 1'b0;
                        l2_en_q <= 1'b1;
                        state_q <= L2;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        l1_en_q    <= 1'b0;
                        err_q      <= 1'b1;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                L2: begin
                    if (l2_valid_i) begin
                        out_y_q     <= l2_y_i;
                        cnt_q       <= '0;
                        l2_en_q     <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        l2_en_q    <= 1'b0;
                        err_q      <= 1'b1;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                OUT: begin
                    if (str.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Layer-2 addresses are relative to its block of the ROM and wrap at the ROM size.
    assign l2_addr_abs = AW'(L2_BASE) + l2_rom_addr_i;

    always_comb begin
        rom_addr_o = '0;
        if (state_q == L1) begin
            rom_addr_o = l1_rom_addr_i;
        end else if (state_q == L2) begin
            rom_addr_o = l2_addr_abs;
        end
    end

    assign l1_en_o       = l1_en_q;
    assign l1_x_o        = l1_x_q;
    assign l2_en_o       = l2_en_q;
    assign l2_h_o        = l2_h_q;
    assign str.in_ready  = in_ready_q;
    assign str.out_valid = out_valid_q;
    assign str.out_y     = out_y_q;
    assign busy_o        = busy_q;
    assign err_timeout_o = err_q;
endmodule

// File: tb/tb_bp_net_seq.sv
// Randomized scoreboard bench for bp_net_seq with behavioural layer models.
// The bench predicts each transaction's outcome (result or stage timeout) from the stage latencies.
module tb_bp_net_seq;
    localparam int XW = 9;
    localparam int DW = 32;
    localparam int NH = 4;
    localparam int AW = 6;
    localparam int L2_BASE = 40;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_net_seq_if #(.XW(XW), .DW(DW)) str ();

    logic               l1_en_o;
    logic [XW-1:0]      l1_x_o;
    logic               l1_valid;
    logic [NH*DW-1:0]   l1_y;
    logic [AW-1:0]      l1_rom_addr;
    logic               l2_en_o;
    logic [NH*DW-1:0]   l2_h_o;
    logic               l2_valid;
    logic [DW-1:0]      l2_y;
    logic [AW-1:0]      l2_rom_addr;
    logic [AW-1:0]      rom_addr_o;
    logic               busy_o;
    logic               err_timeout_o;

    bp_net_seq #(
        .XW(XW), .DW(DW), .NH(NH), .AW(AW), .L2_BASE(L2_BASE), .TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .str           (str),
        .l1_en_o       (l1_en_o),
        .l1_x_o        (l1_x_o),
        .l1_valid_i    (l1_valid),
        .l1_y_i        (l1_y),
        .l1_rom_addr_i (l1_rom_addr),
        .l2_en_o       (l2_en_o),
        .l2_h_o        (l2_h_o),
        .l2_valid_i    (l2_valid),
        .l2_y_i        (l2_y),
        .l2_rom_addr_i (l2_rom_addr),
        .rom_addr_o    (rom_addr_o),
        .busy_o        (busy_o),
        .err_timeout_o (err_timeout_o)
    );

    typedef struct {
        bit            isTimeout;
        logic [DW-1:0] y;
    } exp_t;

    exp_t             expQ[$];
    int               total = 0;
    int               bad = 0;
    int               doneCount = 0;
    int               expectDone = 0;
    logic [XW-1:0]    curX = '0;
    int               curLat1 = 1;
    int               curLat2 = 1;
    logic [NH*DW-1:0] curY1 = '0;
    logic [DW-1:0]    curY2 = '0;
    int               holdTarget = 0;
    bit               directedAddr = 1'b0;
    bit               resetAbort = 1'b0;
    logic [DW-1:0]    lastOutY = '0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A stage runs for its latency if the valid arrives within TO+1 cycles, else exactly TO+1 cycles.
    function automatic int expLen(input int lat);
        return (lat <= TO + 1) ? lat : TO + 1;
    endfunction

    task automatic applyStimulus(input logic [XW-1:0] x, input int lat1, input int lat2,
                                 input logic [NH*DW-1:0] y1, input logic [DW-1:0] y2,
                                 input int hold);
        exp_t e;
        curX = x;
        curLat1 = lat1;
        curLat2 = lat2;
        curY1 = y1;
        curY2 = y2;
        holdTarget = hold;
        e.isTimeout = (lat1 > TO + 1) || ((lat1 <= TO + 1) && (lat2 > TO + 1));
        e.y = y2;
        expQ.push_back(e);
        @(negedge clk);
        str.in_x = x;
        str.in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("accept_l1_en", l1_en_o, 1);
        checkOutput("accept_in_ready", str.in_ready, 0);
        str.in_valid = 1'b0;
    endtask

    // Waits for the transaction to retire, offering junk samples while the result is pending.
    task automatic waitDone();
        int guard = 0;
        expectDone++;
        while (doneCount < expectDone && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (str.out_valid) begin
                str.in_valid = 1'b1;
                str.in_x = XW'($urandom);
            end else begin
                str.in_valid = 1'b0;
            end
        end
        str.in_valid = 1'b0;
        if (guard >= 3000) begin
            total++;
            bad++;
            $display("[TB] FAIL txn_timeout: got done=%0d want %0d", doneCount, expectDone);
            doneCount = expectDone;
        end
        @(posedge clk);
        #1;
        checkOutput("idle_busy", busy_o, 0);
        checkOutput("idle_in_ready", str.in_ready, 1);
    endtask

    // Layer models: raise valid after the programmed latency, drive junk data otherwise.
    initial begin : responder
        int l1Cnt = 0;
        int l2Cnt = 0;
        bit l1Hit;
        bit l2Hit;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [AW-1:0] expAddr;
        l1_valid = 1'b0;
        l2_valid = 1'b0;
        l1_y = '0;
        l2_y = '0;
        l1_rom_addr = '0;
        l2_rom_addr = '0;
        forever begin
            @(negedge clk);
            a1 = directedAddr ? 6'd5 : AW'($urandom);
            a2 = directedAddr ? 6'd30 : AW'($urandom);
            l1_rom_addr = a1;
            l2_rom_addr = a2;
            l1Hit = 1'b0;
            l2Hit = 1'b0;
            if (rst) begin
                l1Cnt = 0;
                l2Cnt = 0;
            end else begin
                if (l1_en_o) begin
                    l1Cnt++;
                    l1Hit = (l1Cnt == curLat1);
                    checkOutput("l1_x", l1_x_o, curX);
                end else begin
                    if (l1Cnt > 0 && !resetAbort) checkOutput("l1_len", l1Cnt, expLen(curLat1));
                    l1Cnt = 0;
                end
                if (l2_en_o) begin
                    l2Cnt++;
                    l2Hit = (l2Cnt == curLat2);
                    checkOutput("l2_h_held", l2_h_o, curY1);
                end else begin
                    if (l2Cnt > 0 && !resetAbort) checkOutput("l2_len", l2Cnt, expLen(curLat2));
                    l2Cnt = 0;
                end
            end
            l1_valid = l1Hit || (str.out_valid && ($urandom_range(1) == 1));
            l2_valid = l2Hit || (str.out_valid && ($urandom_range(1) == 1));
            l1_y = l1Hit ? curY1 : {$urandom, $urandom, $urandom, $urandom};
            l2_y = l2Hit ? curY2 : $urandom;
            #1;
            expAddr = l1_en_o ? a1 : (l2_en_o ? AW'((L2_BASE + int'(a2)) % (1 << AW)) : '0);
            checkOutput("rom_addr", rom_addr_o, expAddr);
            checkOutput("en_exclusive", l1_en_o & l2_en_o, 0);
        end
    end

    // Monitor and consumer: pops an expectation on every retired result or timeout pulse.
    initial begin : monitor
        int waitCnt = 0;
        exp_t e;
        str.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                expQ.delete();
                waitCnt = 0;
                str.out_ready = 1'b0;
                lastOutY = '0;
            end else begin
                if (err_timeout_o) begin
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL spurious_timeout: got pulse want none at %0t", $time);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("timeout_expected", 1, e.isTimeout);
                        checkOutput("timeout_out_y", str.out_y, lastOutY);
                        checkOutput("timeout_out_valid", str.out_valid, 0);
                        checkOutput("timeout_busy", busy_o, 0);
                        doneCount++;
                    end
                end
                if (str.out_valid) begin
                    waitCnt++;
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL spurious_out: got out_valid want none at %0t", $time);
                        str.out_ready = 1'b1;
                    end else begin
                        checkOutput("out_y_held", str.out_y, expQ[0].y);
                        if (waitCnt > holdTarget) begin
                            str.out_ready = 1'b1;
                            waitCnt = 0;
                            e = expQ.pop_front();
                            checkOutput("result_expected", 0, e.isTimeout);
                            checkOutput("out_y", str.out_y, e.y);
                            lastOutY = e.y;
                            doneCount++;
                        end else begin
                            str.out_ready = 1'b0;
                        end
                    end
                end else begin
                    waitCnt = 0;
                    str.out_ready = 1'b0;
                end
            end
        end
    end

    initial begin : driver
        str.in_valid = 1'b0;
        str.in_x = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", str.in_ready, 1);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_l1_en", l1_en_o, 0);
        checkOutput("rst_l2_en", l2_en_o, 0);
        checkOutput("rst_out_valid", str.out_valid, 0);
        checkOutput("rst_err", err_timeout_o, 0);
        checkOutput("rst_out_y", str.out_y, 0);
        checkOutput("rst_l2_h", l2_h_o, 0);
        checkOutput("rst_l1_x", l1_x_o, 0);
        checkOutput("rst_rom_addr", rom_addr_o, 0);
        rst = 1'b0;

        directedAddr = 1'b1;
        applyStimulus(9'h13A, 10, 6, {4{32'h3A580000}}, 32'h3F80_0000, 0);
        waitDone();
        directedAddr = 1'b0;

        applyStimulus(9'h055, 1000, 5, {$urandom, $urandom, $urandom, $urandom}, $urandom, 0);
        waitDone();
        applyStimulus(9'h1FF, TO + 1, 5, {$urandom, $urandom, $urandom, $urandom}, $urandom, 1);
        waitDone();
        applyStimulus(9'h001, TO + 2, 5, {$urandom, $urandom, $urandom, $urandom}, $urandom, 0);
        waitDone();
        applyStimulus(9'h0AA, 4, TO + 1, {$urandom, $urandom, $urandom, $urandom}, $urandom, 0);
        waitDone();
        applyStimulus(9'h123, 4, TO + 2, {$urandom, $urandom, $urandom, $urandom}, $urandom, 0);
        waitDone();

        applyStimulus(9'h0F0, 3, 100, {$urandom, $urandom, $urandom, $urandom}, $urandom, 0);
        repeat (8) @(negedge clk);
        checkOutput("pre_reset_l2_en", l2_en_o, 1);
        resetAbort = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_l2_en", l2_en_o, 0);
        checkOutput("midrst_busy", busy_o, 0);
        checkOutput("midrst_out_valid", str.out_valid, 0);
        checkOutput("midrst_in_ready", str.in_ready, 1);
        checkOutput("midrst_out_y", str.out_y, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        resetAbort = 1'b0;

        applyStimulus(9'h1C3, 7, 9, {$urandom, $urandom, $urandom, $urandom}, $urandom, 20);
        waitDone();

        for (int i = 0; i < 40; i++) begin
            applyStimulus(XW'($urandom), int'($urandom_range(12, 1)), int'($urandom_range(12, 1)),
                          {$urandom, $urandom, $urandom, $urandom}, $urandom,
                          int'($urandom_range(3, 0)));
            waitDone();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish want finish by 1ms");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
